lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store unit sitting directly downstream of the ALU in the RISC-V core: takes the ALU result as the effective address and drives a word-wide data-memory port with a req/gnt/rvalid handshake. Generates byte enables, replicates store data by lane, and extracts and sign- or zero-extends load data. Holds the core via `stall` until the access completes, and flags misaligned, illegal-size and timed-out accesses.

## Interface
- `TIMEOUT`, 255: cycles waited in REQ or WAIT before a bus-error exception (1..65535).
- `clk` in 1: core clock, all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: execute stage presents a memory op; inputs stable while `stall`=1.
- `req_we` in 1: 1=store, 0=load.
- `req_funct3` in 3: RISC-V funct3 (loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW).
- `req_addr` in 32: effective address (ALU output).
- `req_wdata` in 32: store data (rs2).
- `stall` out 1: combinational, `req_valid & ~done`.
- `done` out 1: one-cycle pulse, access finished or aborted.
- `rdata` out 32: extended load result, valid when `done`=1 and `exc`=00; otherwise 0.
- `exc` out 2: with `done`; 00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write strobe.
- `mem_addr` out 32: `{req_addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: load data valid.
- `mem_rdata` in 32: load data word.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE, `req_valid`=1:
  - illegal funct3 (011, 110, 111; any 1xx on store) -> DONE, `exc`=10, no memory access.
  - else misaligned (half with `addr[0]`=1, word with `addr[1:0]`!=0) -> DONE, `exc`=01, no memory access.
  - else -> REQ; latch address, size, sign, store data and byte offset.
- REQ: `mem_req`=1 every cycle until `mem_gnt`.
  - on `mem_gnt`: store -> DONE; load -> WAIT.
- WAIT: on `mem_rvalid`, capture extracted data -> DONE.
  - `mem_rvalid` is ignored in every state except WAIT.
- DONE: `done`=1 for exactly one cycle -> IDLE. A new request is accepted no earlier than the following IDLE cycle.
- Timeout: counter clears on entry to REQ and counts in REQ and WAIT. At `TIMEOUT` cycles -> DONE with `exc`=11; `mem_req` drops.
- Byte enables: byte = `4'b0001<<off`; half = `off[1]?1100:0011`; word = 1111. Loads drive the same `mem_be`.
- Store data: byte = `{4{wdata[7:0]}}`; half = `{2{wdata[15:0]}}`; word as-is.
- Load extract: `w = mem_rdata >> (8*off)`.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW = `w`.
- Reset (`rst_n`=0 at an edge), including mid-access: state -> IDLE, counter 0, all registered outputs 0. A `mem_gnt` or `mem_rvalid` in flight after reset is ignored.

## Timing
- Reset values: `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `done`, `exc`, `rdata` all 0.
- `stall`=1 whenever `req_valid`=1 and `done`=0.
- All `mem_*` outputs and `done`/`exc`/`rdata` are registered from state; no combinational path from `mem_*` inputs to `mem_*` outputs.
- Load with zero-wait memory (`gnt` in the first REQ cycle, `rvalid` in the first WAIT cycle):
  - accept edge 0; REQ cycle 1; WAIT cycle 2; `done` cycle 3.
  - `stall` high for cycles 0-2, low on cycle 3.
- Store with zero-wait memory: accept edge 0; REQ cycle 1; `done` cycle 2.
- Error path: `done` with `exc`!=00 on cycle 1 after accept; `mem_req` never asserted.
- Each `mem_gnt` wait cycle adds one cycle; each `mem_rvalid` wait cycle adds one cycle.

## Test plan
- SW addr 0x104, wdata 0xDEADBEEF, gnt in first REQ cycle -> `mem_addr`=0x104, `mem_be`=1111, `mem_wdata`=0xDEADBEEF; `done` 2 cycles after accept, `exc`=00.
- SB addr 0x203, wdata 0x000000A5 -> `mem_addr`=0x200, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5.
- SH addr 0x202 -> `mem_be`=1100, `mem_wdata`=`{2{wdata[15:0]}}`.
- LB addr 0x302, `mem_rdata`=0x12F45678 -> `rdata`=0xFFFFFFF4.
  - LBU same address and data -> 0x000000F4.
  - LHU addr 0x302, same data -> 0x000012F4.
  - In each case `done` 3 cycles after accept with zero-wait memory.
- LH addr 0x401 -> `done` on cycle 1, `exc`=01, `mem_req` never high.
  - funct3=011 -> `exc`=10.
  - SB with funct3=100 -> `exc`=10.
- TIMEOUT=4, `mem_gnt` held 0 -> `mem_req` high 4 cycles then low, `done` with `exc`=11.
  - Repeat with `rst_n`=0 asserted in WAIT -> next cycle IDLE, all outputs 0; a late `mem_rvalid` produces no `done`.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns an ALU effective address into one word-wide
// req/gnt/rvalid data-memory access. It generates byte enables and
// lane-replicated store data, and it sign- or zero-extends load data.
// The core is held on stall until done pulses. An access that breaks
// the rules finishes at once with an exception code and never reaches
// the bus.
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | no access in flight; a valid request is decoded here
// S_REQ  | mem_req asserted, waiting for mem_gnt
// S_WAIT | load granted, waiting for mem_rvalid
// S_DONE | one-cycle done pulse carrying exc/rdata
module lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  exc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [15:0] TC_LOAD = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic        r_done;
    logic [1:0]  r_exc;
    logic [31:0] r_rdata;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;

    logic        w_illegal;
    logic        w_misal;
    logic        w_accept;
    logic        w_tc;
    logic [1:0]  w_exc;
    logic [31:0] w_rdata;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load;

    // Request decode: 011 and 11x are never legal, and stores have no 1xx forms
    assign w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_we && req_funct3[2]);
    assign w_misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_accept  = (r_state == S_IDLE) && req_valid && !w_illegal && !w_misal;
    assign w_tc      = (r_cnt == 16'd0);

    // Lane steering for the incoming request
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load data extraction from the latched byte offset and size/sign
    assign w_shift = mem_rdata >> {r_off, 3'b000};
    always_comb begin
        w_load = w_shift;
        case (r_f3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load = {24'h0, w_shift[7:0]};
            3'b101:  w_load = {16'h0, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    // Next state and the exception/result that go with entry to S_DONE
    always_comb begin
        w_next  = r_state;
        w_exc   = 2'b00;
        w_rdata = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_illegal) begin
                        w_next = S_DONE;
                        w_exc  = 2'b10;
                    end else if (w_misal) begin
                        w_next = S_DONE;
                        w_exc  = 2'b01;
                    end else begin
                        w_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    w_next = r_we ? S_DONE : S_WAIT;
                end else if (w_tc) begin
                    w_next = S_DONE;
                    w_exc  = 2'b11;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_next  = S_DONE;
                    w_rdata = w_load;
                end else if (w_tc) begin
                    w_next = S_DONE;
                    w_exc  = 2'b11;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Registered outputs, request latch and timeout down-counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= 16'd0;
            r_we        <= 1'b0;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_done      <= 1'b0;
            r_exc       <= 2'b00;
            r_rdata     <= 32'h0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_be    <= 4'h0;
            r_mem_wdata <= 32'h0;
        end else begin
            r_done    <= (w_next == S_DONE);
            r_exc     <= w_exc;
            r_rdata   <= w_rdata;
            r_mem_req <= (w_next == S_REQ);
            r_mem_we  <= (w_next == S_REQ) && (w_accept ? req_we : r_we);
            if (w_accept) begin
                r_cnt       <= TC_LOAD;
                r_we        <= req_we;
                r_f3        <= req_funct3;
                r_off       <= req_addr[1:0];
                r_mem_addr  <= {req_addr[31:2], 2'b00};
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wdata;
            end else if (((r_state == S_REQ) || (r_state == S_WAIT)) && !w_tc) begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    assign stall     = req_valid & ~r_done;
    assign done      = r_done;
    assign exc       = r_exc;
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule
